// File: rtl/systolic_skew_feeder_pkg.sv
// Shared definitions for the systolic skew feeder: default sizes, FSM state
// encoding and the row-major flat-index helper used to address packed matrices.
package systolic_skew_feeder_pkg;

  localparam int DW_DEF = 2;
  localparam int N_DEF  = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FEED  = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

  // Element (i,k) of an n x n row-major matrix sits at flat slot i*n+k.
  function automatic int idx(input int i, input int k, input int n);
    return i * n + k;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_lane_sel.sv
// One skewed lane: at step k, row lane i carries A[i][k-i] and column lane j
// carries B[k-j][j]; anything outside the effective M x M window reads as 0.
module skew_lane_sel
  import systolic_skew_feeder_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int N      = N_DEF,
  parameter int LANE   = 0,
  parameter bit IS_COL = 1'b0,
  parameter int KW     = 4,
  parameter int MW     = 2
) (
  input  logic [N*N*DW-1:0] mat_i,
  input  logic [KW-1:0]     k_i,
  input  logic [MW-1:0]     m_i,
  output logic [DW-1:0]     elem_o
);

  // Scan the lane's diagonal offsets; at most one offset t matches k = LANE + t.
  always_comb begin
    elem_o = '0;
    for (int t = 0; t < N; t++) begin
      if (LANE < int'(m_i) && t < int'(m_i) && int'(k_i) == LANE + t) begin
        if (IS_COL)
          elem_o = mat_i[idx(t, LANE, N)*DW +: DW];
        else
          elem_o = mat_i[idx(LANE, t, N)*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skewed operand feeder for the NxN systolic multiplier. Latches A, B and the
// mode on start, streams the diagonally skewed rows/columns, drains the grid
// for M cycles and pulses done. Define SKEW_FEEDER_JOBCNT_EN to add an 8-bit
// wrapping job_count output.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | waiting for start; outputs zero, busy low
//   FEED     | loading skew steps k = 1 .. 2M-2 onto row_out/col_out
//   DRAIN    | zero operands for M edges while the grid finishes; done on last
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int N  = N_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode_2x2,
  input  logic [N*N*DW-1:0] a_flat,
  input  logic [N*N*DW-1:0] b_flat,
  output logic [N*DW-1:0]   row_out,
  output logic [N*DW-1:0]   col_out,
  output logic              array_mode,
  output logic              busy,
  output logic              done
`ifdef SKEW_FEEDER_JOBCNT_EN
  , output logic [7:0]      job_count
`endif
);

  localparam int KW = $clog2(3*N);
  localparam int MW = $clog2(N+1);

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [MW-1:0]     m_q, m_d;
  logic [N*N*DW-1:0] a_q, a_d, b_q, b_d;
  logic [N*DW-1:0]   row_q, row_d, col_q, col_d;
  logic              mode_q, mode_d, busy_q, busy_d, done_q, done_d;

  logic              idle;
  logic [N*N*DW-1:0] src_a, src_b;
  logic [KW-1:0]     sel_k;
  logic [MW-1:0]     sel_m;
  logic [N*DW-1:0]   row_sel, col_sel;
  logic              feed_last, drain_last;

  // In IDLE the step-0 values come straight from the inputs so they can be
  // registered on the same edge that accepts the job.
  assign idle       = (state_q == ST_IDLE);
  assign src_a      = idle ? a_flat : a_q;
  assign src_b      = idle ? b_flat : b_q;
  assign sel_k      = idle ? '0 : k_q;
  assign sel_m      = idle ? (mode_2x2 ? MW'(N-1) : MW'(N)) : m_q;
  assign feed_last  = (k_q == KW'(2*int'(m_q) - 2));
  assign drain_last = (k_q == KW'(3*int'(m_q) - 2));

  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_lane_sel #(.DW(DW), .N(N), .LANE(g), .IS_COL(1'b0), .KW(KW), .MW(MW)) u_row (
      .mat_i (src_a),
      .k_i   (sel_k),
      .m_i   (sel_m),
      .elem_o(row_sel[g*DW +: DW])
    );
    skew_lane_sel #(.DW(DW), .N(N), .LANE(g), .IS_COL(1'b1), .KW(KW), .MW(MW)) u_col (
      .mat_i (src_b),
      .k_i   (sel_k),
      .m_i   (sel_m),
      .elem_o(col_sel[g*DW +: DW])
    );
  end

  // Job sequencing: accept, feed the skewed steps, drain, then pulse done.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    m_d     = m_q;
    a_d     = a_q;
    b_d     = b_q;
    row_d   = row_q;
    col_d   = col_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a_flat;
          b_d     = b_flat;
          mode_d  = mode_2x2;
          m_d     = sel_m;
          row_d   = row_sel;
          col_d   = col_sel;
          k_d     = KW'(1);
          busy_d  = 1'b1;
          state_d = ST_FEED;
        end
      end
      ST_FEED: begin
        row_d = row_sel;
        col_d = col_sel;
        k_d   = k_q + KW'(1);
        if (feed_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        row_d = '0;
        col_d = '0;
        k_d   = k_q + KW'(1);
        if (drain_last) begin
          k_d     = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        row_d   = '0;
        col_d   = '0;
        k_d     = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any job without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      m_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      m_q     <= m_d;
      a_q     <= a_d;
      b_q     <= b_d;
      row_q   <= row_d;
      col_q   <= col_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign row_out    = row_q;
  assign col_out    = col_q;
  assign array_mode = mode_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef SKEW_FEEDER_JOBCNT_EN
  logic [7:0] jobs_q;

  // Completed-job counter, advanced on the edge that raises done; wraps at 256.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      jobs_q <= 8'd0;
    else if (done_d)
      jobs_q <= jobs_q + 8'd1;
  end

  assign job_count = jobs_q;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: expected per-cycle outputs are
// queued when a job is launched and popped on every falling edge. A small
// output-stationary grid model consumes the streams to confirm the product.
module tb_systolic_skew_feeder;

  localparam int DW = 2;
  localparam int N  = 3;
  localparam int LW = N*DW;
  localparam int FW = N*N*DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode_2x2;
  logic [FW-1:0] a_flat, b_flat;
  logic [LW-1:0] row_out, col_out;
  logic          array_mode, busy, done;
`ifdef SKEW_FEEDER_JOBCNT_EN
  logic [7:0]    job_count;
`endif

  always #5 clk = ~clk;

  systolic_skew_feeder #(.DW(DW), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode_2x2  (mode_2x2),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .row_out   (row_out),
    .col_out   (col_out),
    .array_mode(array_mode),
    .busy      (busy),
    .done      (done)
`ifdef SKEW_FEEDER_JOBCNT_EN
    , .job_count(job_count)
`endif
  );

  localparam int AM[3][3] = '{'{0,1,1}, '{3,2,3}, '{2,2,1}};
  localparam int BM[3][3] = '{'{1,0,0}, '{0,3,2}, '{1,1,2}};
  localparam int C3[3][3] = '{'{1,4,4}, '{6,9,10}, '{3,7,6}};
  localparam int C2[3][3] = '{'{0,3,0}, '{3,6,0}, '{0,0,0}};

  typedef struct {
    logic [LW-1:0] row;
    logic [LW-1:0] col;
    logic          busy;
    logic          done;
    logic          amode;
    bit            first;
    int            m;
  } exp_t;

  exp_t sb_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   jobs_exp  = 0;
  int   done_seen = 0;
  int   acc[3][3];
  int   ar[3][3];
  int   br[3][3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] pack(input bit use_b);
    logic [FW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++)
        v[(i*N+k)*DW +: DW] = use_b ? DW'(BM[i][k]) : DW'(AM[i][k]);
    return v;
  endfunction

  function automatic logic [LW-1:0] lanes(input int k, input int m, input bit is_col);
    logic [LW-1:0] v;
    v = '0;
    for (int l = 0; l < N; l++)
      if (l < m && k >= l && k - l < m)
        v[l*DW +: DW] = is_col ? DW'(BM[k-l][l]) : DW'(AM[l][k-l]);
    return v;
  endfunction

  // Queue the expected outputs after edges E0 .. E0+n_ent-1, optionally
  // followed by one idle cycle.
  task automatic push_job(input bit mode, input int n_ent, input bit idle_tail);
    exp_t e;
    int   m;
    m = mode ? N-1 : N;
    for (int c = 0; c < n_ent && c <= 3*m-2; c++) begin
      e.row   = lanes(c, m, 1'b0);
      e.col   = lanes(c, m, 1'b1);
      e.busy  = (c != 3*m-2);
      e.done  = (c == 3*m-2);
      e.amode = mode;
      e.first = (c == 0);
      e.m     = m;
      sb_q.push_back(e);
    end
    if (n_ent >= 3*m-1) jobs_exp++;
    if (idle_tail) begin
      e.row   = '0;
      e.col   = '0;
      e.busy  = 1'b0;
      e.done  = 1'b0;
      e.amode = mode;
      e.first = 1'b0;
      e.m     = m;
      sb_q.push_back(e);
    end
  endtask

  task automatic grid_step();
    int na[3][3];
    int nb[3][3];
    int a_in, b_in;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a_in = (j == 0) ? int'(row_out[i*DW +: DW]) : ar[i][j-1];
        b_in = (i == 0) ? int'(col_out[j*DW +: DW]) : br[i-1][j];
        acc[i][j] += a_in * b_in;
        na[i][j] = a_in;
        nb[i][j] = b_in;
      end
    ar = na;
    br = nb;
  endtask

  task automatic monitor_step();
    exp_t e;
    done_seen += int'(done);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.first)
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            acc[i][j] = 0;
            ar[i][j]  = 0;
            br[i][j]  = 0;
          end
      grid_step();
      chk("row_out",    32'(row_out),    32'(e.row));
      chk("col_out",    32'(col_out),    32'(e.col));
      chk("busy",       32'(busy),       32'(e.busy));
      chk("done",       32'(done),       32'(e.done));
      chk("array_mode", 32'(array_mode), 32'(e.amode));
      if (e.done)
        for (int i = 0; i < e.m; i++)
          for (int j = 0; j < e.m; j++)
            chk($sformatf("C[%0d][%0d]", i, j), 32'(acc[i][j]),
                32'((e.m == N) ? C3[i][j] : C2[i][j]));
    end
  endtask

  task automatic run_job(input bit mode);
    int m;
    m = mode ? N-1 : N;
    @(negedge clk); #1;
    a_flat   = pack(1'b0);
    b_flat   = pack(1'b1);
    mode_2x2 = mode;
    start    = 1'b1;
    push_job(mode, 99, 1'b1);
    @(negedge clk); #1;
    start = 1'b0;
    repeat (3*m-1) @(negedge clk);
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_row"},   32'(row_out),    32'd0);
    chk({tag, "_col"},   32'(col_out),    32'd0);
    chk({tag, "_busy"},  32'(busy),       32'd0);
    chk({tag, "_done"},  32'(done),       32'd0);
    chk({tag, "_amode"}, 32'(array_mode), 32'd0);
`ifdef SKEW_FEEDER_JOBCNT_EN
    chk({tag, "_jobcnt"}, 32'(job_count), 32'd0);
`endif
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    mode_2x2 = 1'b0;
    a_flat   = '0;
    b_flat   = '0;
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    #12;
    zero_outputs("reset");
    @(negedge clk); #1;
    rst = 1'b0;

    // 3x3 job, then 2x2 job
    run_job(1'b0);
    run_job(1'b1);

    // start pulses and operand changes while busy are ignored
    @(negedge clk); #1;
    a_flat = pack(1'b0); b_flat = pack(1'b1); mode_2x2 = 1'b0; start = 1'b1;
    push_job(1'b0, 99, 1'b1);
    @(negedge clk); #1;
    start = 1'b0; a_flat = FW'($urandom); mode_2x2 = 1'b1;
    @(negedge clk); #1;
    start = 1'b1; b_flat = FW'($urandom);
    repeat (3) @(negedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);

    // back-to-back: start held, second job (2x2) launches on the edge after done
    @(negedge clk); #1;
    a_flat = pack(1'b0); b_flat = pack(1'b1); mode_2x2 = 1'b0; start = 1'b1;
    push_job(1'b0, 99, 1'b0);
    push_job(1'b1, 99, 1'b1);
    @(negedge clk); #1;
    mode_2x2 = 1'b1;
    repeat (8) @(negedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);

    // reset asserted just after E0+3 abandons the job
    @(negedge clk); #1;
    a_flat = pack(1'b0); b_flat = pack(1'b1); mode_2x2 = 1'b0; start = 1'b1;
    push_job(1'b0, 4, 1'b0);
    @(negedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1 zero_outputs("abort");
    chk("abort_sb_drained", 32'(sb_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    run_job(1'b0);

`ifdef SKEW_FEEDER_JOBCNT_EN
    @(negedge clk); #1 rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    chk("jobcnt_cleared", 32'(job_count), 32'd0);
    for (int j = 0; j < 257; j++) run_job(j[0]);
    chk("jobcnt_wrap", 32'(job_count), 32'd1);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("done_count", 32'(done_seen),   32'(jobs_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
